multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the two-phase fetch/execute controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and stalls on a memory ready handshake, so memory may take any number of cycles.
- Drives datapath mux selects, the ALU op, and the PC/IR/register-file/memory enables.
- Sits between the instruction register and the datapath of the 16-opcode core.

Parameters:
- OPCODE_W, 4, opcode width (≥4). Codes above 4'hF are illegal.
- ALU_W, 4, ALU op field width (≥4). Upper bits are zero.
- TIMEOUT_CYCLES, 64, memory wait limit. Used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  active-low asynchronous reset
- opcode  in  OPCODE_W  current IR opcode; valid from DECODE onward
- eq  in  1  register-compare equal flag from the datapath
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store strobe, qualified by mem_req
- addr_sel  out  1  0 = PC address, 1 = ALU result address
- ir_we  out  1  instruction register load
- mdr_we  out  1  memory data register load
- pc_we  out  1  PC update
- pc_sel  out  2  0 = PC+1, 1 = branch target, 2 = jump target
- alu_b_sel  out  1  0 = register, 1 = immediate
- wb_sel  out  1  0 = ALU result, 1 = MDR
- rf_we  out  1  register-file write
- alu_op  out  ALU_W  ALU function code
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse on an illegal opcode in EXEC
- bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- State register:
  - Asynchronously reset to FETCH; while reset is low, every output is forced to 0.
  - All outputs are combinational from state, opcode, eq and mem_ready.
  - Any output not listed for a state is 0.
- FETCH: mem_req=1, addr_sel=0.
  - mem_ready=0: stay in FETCH.
  - mem_ready=1: ir_we=1, go to DECODE.
- DECODE: no enables; always go to EXEC.
- EXEC: alu_op and alu_b_sel are decoded from opcode (below).
  - ALU/immediate ops: go to WB.
  - lw (E) / sw (F): go to MEM.
  - j (7): pc_we=1, pc_sel=2, retire=1, go to FETCH.
  - beq (8): pc_we=1, pc_sel=eq?1:0, retire=1, go to FETCH.
  - bne (9): pc_we=1, pc_sel=eq?0:1, retire=1, go to FETCH.
  - Illegal opcode: illegal=1, pc_we=1, pc_sel=0, retire=0, go to FETCH.
- MEM: mem_req=1, addr_sel=1, alu_b_sel=1, alu_op=4 (address add); mem_we=1 for sw.
  - mem_ready=0: stay in MEM.
  - mem_ready=1, lw: mdr_we=1, go to WB.
  - mem_ready=1, sw: pc_we=1, pc_sel=0, retire=1, go to FETCH.
- WB: rf_we=1, pc_we=1, pc_sel=0, retire=1, go to FETCH.
  - wb_sel=1 for lw, 0 otherwise.
  - alu_op and alu_b_sel are held at their EXEC values.
- Opcode decode (alu_op / alu_b_sel):
  - 0–6 and/or/xor/not/add/sub/cmp: alu_op = opcode, b_sel=0.
  - A sl, B sr: alu_op = opcode, b_sel=1.
  - C addi: alu_op=4, b_sel=1.
  - D lui: alu_op=D, b_sel=1.
- Latency with zero-wait memory (mem_ready high on the first request cycle):
  - ALU ops: 4 cycles.
  - Jump/branch: 3 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Each wait cycle adds 1.
- Boundary conditions:
  - mem_ready outside FETCH/MEM is ignored.
  - Reset asserted mid-instruction aborts it; no retire pulse is produced.
  - Opcode changes after DECODE are not guarded; the IR holds opcode stable.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TIMEOUT_EN.
- With the macro:
  - A wait counter, clog2(TIMEOUT_CYCLES)+1 bits, clears on entering FETCH or MEM and counts each cycle with mem_req=1 and mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 without mem_ready, bus_err pulses and the state goes to FETCH.
  - From FETCH: the PC is unchanged and the fetch is retried.
  - From MEM: pc_we=1, pc_sel=0, no mdr_we, no retire.
- Without the macro: waits are unbounded, bus_err is tied 0, and no counter exists.

Test Plan:
- Reset low mid-MEM, mem_req=1 → state=0 and all outputs 0 immediately, asynchronously. Release → FETCH with mem_req=1 on the next cycle.
- add (4), mem_ready always 1 → states 0,1,2,4. In WB: rf_we=1, alu_op=4, wb_sel=0, retire=1.
- beq (8) with eq=1 → EXEC pc_we=1, pc_sel=1. With eq=0 → pc_sel=0. bne with eq=1 → pc_sel=0. Each takes 3 cycles.
- lw (E), mem_ready low 3 cycles in MEM → MEM held 4 cycles, mdr_we on the 4th. WB: wb_sel=1, rf_we=1. Total 8 cycles.
- sw (F) → MEM mem_we=1, addr_sel=1. Then FETCH with retire=1 and no rf_we.
- MULTICYCLE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready stuck low in FETCH → bus_err pulses on the 4th wait cycle and FETCH retries. OPCODE_W=5, opcode 5'h13 → illegal=1, pc_sel=0, no retire.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB controller with memory ready handshake.
// Define MULTICYCLE_CTRL_TIMEOUT_EN to bound memory waits and raise bus_err on timeout.
module multicycle_control #(
   parameter int OPCODE_W       = 4,
   parameter int ALU_W          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                eq,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                addr_sel,
   output logic                ir_we,
   output logic                mdr_we,
   output logic                pc_we,
   output logic [1:0]          pc_sel,
   output logic                alu_b_sel,
   output logic                wb_sel,
   output logic                rf_we,
   output logic [ALU_W-1:0]    alu_op,
   output logic [2:0]          state,
   output logic                retire,
   output logic                illegal,
   output logic                bus_err
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
   state_t state_q, state_d;
   logic legal, is_lw, is_sw, dec_bsel, wait_to;
   logic [3:0] op4;
   logic [ALU_W-1:0] dec_alu;

   always_comb begin
      op4      = opcode[3:0];
      legal    = opcode <= OPCODE_W'(15);
      is_lw    = legal && op4 == 4'hE;
      is_sw    = legal && op4 == 4'hF;
      dec_bsel = legal && op4 >= 4'hA && op4 <= 4'hD;
      dec_alu  = !legal ? '0 :
                 (op4 <= 4'h6 || op4 == 4'hA || op4 == 4'hB || op4 == 4'hD) ? ALU_W'(op4) :
                 op4 == 4'hC ? ALU_W'(4) : '0;
   end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign wait_to = (state_q == FETCH || state_q == MEM) && !mem_ready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   // Counter restarts whenever a new wait phase begins, including a retried fetch.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q || bus_err) cnt_d = '0;
      else if (mem_req && !mem_ready) cnt_d = cnt_q + CW'(1);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
`else
   assign wait_to = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= FETCH;
      else state_q <= state_d;

   assign state = state_q;

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      mdr_we    = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      alu_b_sel = 1'b0;
      wb_sel    = 1'b0;
      rf_we     = 1'b0;
      alu_op    = '0;
      retire    = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = DECODE;
            end else if (wait_to) bus_err = 1'b1;
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            alu_op    = dec_alu;
            alu_b_sel = dec_bsel;
            state_d   = FETCH;
            if (!legal) begin
               illegal = 1'b1;
               pc_we   = 1'b1;
            end else if (op4 == 4'h7 || op4 == 4'h8 || op4 == 4'h9) begin
               pc_we  = 1'b1;
               retire = 1'b1;
               pc_sel = op4 == 4'h7 ? 2'd2 : (op4 == 4'h8) == eq ? 2'd1 : 2'd0;
            end else state_d = (is_lw || is_sw) ? MEM : WB;
         end
         MEM: begin
            mem_req   = 1'b1;
            addr_sel  = 1'b1;
            alu_b_sel = 1'b1;
            alu_op    = ALU_W'(4);
            mem_we    = is_sw;
            if (mem_ready) begin
               mdr_we  = !is_sw;
               pc_we   = is_sw;
               retire  = is_sw;
               state_d = is_sw ? FETCH : WB;
            end else if (wait_to) begin
               bus_err = 1'b1;
               pc_we   = 1'b1;
               state_d = FETCH;
            end
         end
         WB: begin
            rf_we     = 1'b1;
            pc_we     = 1'b1;
            retire    = 1'b1;
            wb_sel    = is_lw;
            alu_op    = dec_alu;
            alu_b_sel = dec_bsel;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
      if (!reset) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         addr_sel  = 1'b0;
         ir_we     = 1'b0;
         mdr_we    = 1'b0;
         pc_we     = 1'b0;
         pc_sel    = 2'd0;
         alu_b_sel = 1'b0;
         wb_sel    = 1'b0;
         rf_we     = 1'b0;
         alu_op    = '0;
         retire    = 1'b0;
         illegal   = 1'b0;
         bus_err   = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven instruction vectors plus hand-written wait/reset/timeout sequences.
module tb_multicycle_control;
   logic clk, reset, eq, mem_ready;
   logic [4:0] opcode;
   logic mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, alu_b_sel, wb_sel, rf_we, retire, illegal, bus_err;
   logic [1:0] pc_sel;
   logic [3:0] alu_op;
   logic [2:0] state;
   int total = 0, bad = 0;

   multicycle_control #(.OPCODE_W(5), .ALU_W(4), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .eq(eq), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .rf_we(rf_we),
      .alu_op(alu_op), .state(state), .retire(retire), .illegal(illegal), .bus_err(bus_err));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0] op; logic e; int cyc; logic [23:0] seq; logic [1:0] ps;
      logic ret, ill, rf, wb; logic [3:0] alu; logic bs, mw;
   } vec_t;
   vec_t vt[17];

   int cyc, mdr_n, mem_n;
   logic [23:0] seq;
   logic l_ret, l_ill, l_rf, l_wb, l_bs, l_mw, l_pcwe, l_berr, berr_seen;
   logic [1:0] l_ps;
   logic [3:0] l_alu;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", n, a, e);
      end
   endtask

   // Runs one instruction starting between edges with state at FETCH.
   task automatic run(input logic [4:0] op, input logic e, input int fw, input int mw);
      int f = 0, m = 0;
      logic [2:0] prev;
      logic done = 0;
      opcode = op; eq = e; cyc = 0; seq = 0; mdr_n = 0; mem_n = 0; berr_seen = 0;
      while (!done && cyc < 60) begin
         if (state == 3'd0) begin mem_ready = f >= fw; f++; end
         else if (state == 3'd3) begin mem_ready = m >= mw; m++; end
         else mem_ready = 1'b1;
         #1;
         seq = {seq[20:0], state};
         cyc++;
         if (mdr_we) mdr_n++;
         if (state == 3'd3) mem_n++;
         berr_seen |= bus_err;
         {l_ret, l_ill, l_rf, l_wb, l_bs, l_mw, l_pcwe, l_berr, l_ps, l_alu} =
            {retire, illegal, rf_we, wb_sel, alu_b_sel, mem_we, pc_we, bus_err, pc_sel, alu_op};
         prev = state;
         @(negedge clk);
         if (state == 3'd0 && prev != 3'd0) done = 1;
      end
      if (!done) chk("run_bound", 0, 1);
   endtask

   initial begin
      vt[0]  = '{5'h04, 0, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'h4, 0, 0};
      vt[1]  = '{5'h00, 0, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'h0, 0, 0};
      vt[2]  = '{5'h05, 1, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'h5, 0, 0};
      vt[3]  = '{5'h06, 0, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'h6, 0, 0};
      vt[4]  = '{5'h0A, 0, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'hA, 1, 0};
      vt[5]  = '{5'h0B, 0, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'hB, 1, 0};
      vt[6]  = '{5'h0C, 0, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'h4, 1, 0};
      vt[7]  = '{5'h0D, 0, 4, 24'o124,  2'd0, 1, 0, 1, 0, 4'hD, 1, 0};
      vt[8]  = '{5'h07, 0, 3, 24'o12,   2'd2, 1, 0, 0, 0, 4'h0, 0, 0};
      vt[9]  = '{5'h08, 1, 3, 24'o12,   2'd1, 1, 0, 0, 0, 4'h0, 0, 0};
      vt[10] = '{5'h08, 0, 3, 24'o12,   2'd0, 1, 0, 0, 0, 4'h0, 0, 0};
      vt[11] = '{5'h09, 1, 3, 24'o12,   2'd0, 1, 0, 0, 0, 4'h0, 0, 0};
      vt[12] = '{5'h09, 0, 3, 24'o12,   2'd1, 1, 0, 0, 0, 4'h0, 0, 0};
      vt[13] = '{5'h0E, 0, 5, 24'o1234, 2'd0, 1, 0, 1, 1, 4'h0, 0, 0};
      vt[14] = '{5'h0F, 0, 4, 24'o123,  2'd0, 1, 0, 0, 0, 4'h4, 1, 1};
      vt[15] = '{5'h13, 0, 3, 24'o12,   2'd0, 0, 1, 0, 0, 4'h0, 0, 0};
      vt[16] = '{5'h10, 1, 3, 24'o12,   2'd0, 0, 1, 0, 0, 4'h0, 0, 0};

      reset = 0; eq = 0; mem_ready = 1; opcode = 0;
      #3;
      chk("rst_state", state, 0);
      chk("rst_outs", {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel, alu_b_sel, wb_sel, rf_we, alu_op, retire, illegal, bus_err}, 0);
      repeat (2) @(negedge clk);
      mem_ready = 0;
      reset = 1;
      #1;
      chk("rel_state", state, 0);
      chk("rel_mem_req", mem_req, 1);

      for (int i = 0; i < 17; i++) begin
         run(vt[i].op, vt[i].e, 0, 0);
         chk($sformatf("v%0d_cyc", i), cyc, vt[i].cyc);
         chk($sformatf("v%0d_seq", i), seq, vt[i].seq);
         chk($sformatf("v%0d_pc_sel", i), l_ps, vt[i].ps);
         chk($sformatf("v%0d_pc_we", i), l_pcwe, 1);
         chk($sformatf("v%0d_retire", i), l_ret, vt[i].ret);
         chk($sformatf("v%0d_illegal", i), l_ill, vt[i].ill);
         chk($sformatf("v%0d_rf_we", i), l_rf, vt[i].rf);
         chk($sformatf("v%0d_wb_sel", i), l_wb, vt[i].wb);
         chk($sformatf("v%0d_alu_op", i), l_alu, vt[i].alu);
         chk($sformatf("v%0d_b_sel", i), l_bs, vt[i].bs);
         chk($sformatf("v%0d_mem_we", i), l_mw, vt[i].mw);
      end

      run(5'h0E, 0, 0, 3);
      chk("lw_wait_cyc", cyc, 8);
      chk("lw_wait_mem", mem_n, 4);
      chk("lw_wait_mdr", mdr_n, 1);
      chk("lw_wait_wb_sel", l_wb, 1);
      chk("lw_wait_rf_we", l_rf, 1);

      run(5'h04, 0, 2, 0);
      chk("fetch_wait_cyc", cyc, 6);
      chk("fetch_wait_seq", seq, 24'o000124);

      opcode = 5'h0E;
      for (int i = 0; i < 10 && state != 3'd3; i++) begin
         mem_ready = 1;
         @(negedge clk);
      end
      mem_ready = 0;
      #1;
      chk("mid_mem_state", state, 3);
      chk("mid_mem_req", mem_req, 1);
      #2;
      reset = 0;
      #1;
      chk("abort_state", state, 0);
      chk("abort_outs", {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel, alu_b_sel, wb_sel, rf_we, alu_op, retire, illegal, bus_err}, 0);
      @(negedge clk);
      reset = 1;
      #1;
      chk("abort_rel_state", state, 0);
      chk("abort_rel_mem_req", mem_req, 1);
      chk("abort_rel_retire", retire, 0);
      run(5'h04, 0, 0, 0);
      chk("after_abort_cyc", cyc, 4);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      mem_ready = 0;
      for (int i = 1; i <= 5; i++) begin
         #1;
         chk($sformatf("to_fetch_berr%0d", i), bus_err, i == 4);
         chk($sformatf("to_fetch_state%0d", i), state, 0);
         chk($sformatf("to_fetch_ir_we%0d", i), ir_we, 0);
         @(negedge clk);
      end
      run(5'h0E, 0, 0, 10);
      chk("to_mem_cyc", cyc, 7);
      chk("to_mem_berr", l_berr, 1);
      chk("to_mem_pc_we", l_pcwe, 1);
      chk("to_mem_pc_sel", l_ps, 0);
      chk("to_mem_retire", l_ret, 0);
      chk("to_mem_mdr", mdr_n, 0);
`else
      mem_ready = 0;
      berr_seen = 0;
      repeat (8) begin
         #1;
         berr_seen |= bus_err;
         @(negedge clk);
      end
      chk("no_to_state", state, 0);
      chk("no_to_berr", berr_seen, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
